// File: rtl/imem_loader_if.sv
// Host-side byte stream, control/status and instruction-memory write port of
// the program loader, bundled for module connection.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_hold;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the 16-bit instruction memory: count, words
// (high byte first), 8-bit additive checksum; holds the CPU until a good load.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, COUNT, HI, LO, CSUM, DONE, ERR
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   remaining, rem_nxt;
    logic [7:0]        sum, sum_nxt;
    logic [7:0]        hi_byte, hi_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              we_q, we_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [15:0]       wdata_q, wdata_nxt;
    logic [ADDR_W:0]   cnt_val;
    logic              xfer;

    assign xfer = bus.in_valid && bus.in_ready;

    // A count byte of zero encodes a full-memory frame.
    always_comb begin
        cnt_val = (ADDR_W+1)'(bus.in_data);
        if (bus.in_data == 8'd0)
            cnt_val = (ADDR_W+1)'(1) << ADDR_W;
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        sum_nxt   = sum;
        hi_nxt    = hi_byte;
        idx_nxt   = idx;
        we_nxt    = 1'b0;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        case (state)
            IDLE: if (bus.start) state_nxt = COUNT;
            COUNT: if (xfer) begin
                state_nxt = HI;
                rem_nxt   = cnt_val;
                sum_nxt   = bus.in_data;
                idx_nxt   = '0;
            end
            HI: if (xfer) begin
                state_nxt = LO;
                hi_nxt    = bus.in_data;
                sum_nxt   = sum + bus.in_data;
            end
            LO: if (xfer) begin
                // Write is issued even if the checksum later fails.
                we_nxt    = 1'b1;
                addr_nxt  = ADDR_W'(BASE_ADDR) + idx;
                wdata_nxt = {hi_byte, bus.in_data};
                sum_nxt   = sum + bus.in_data;
                idx_nxt   = idx + ADDR_W'(1);
                rem_nxt   = remaining - (ADDR_W+1)'(1);
                state_nxt = (remaining == (ADDR_W+1)'(1)) ? CSUM : HI;
            end
            CSUM: if (xfer) state_nxt = (bus.in_data == sum) ? DONE : ERR;
            DONE, ERR: if (bus.start) state_nxt = COUNT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            sum       <= '0;
            hi_byte   <= '0;
            idx       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
            sum       <= sum_nxt;
            hi_byte   <= hi_nxt;
            idx       <= idx_nxt;
            we_q      <= we_nxt;
            addr_q    <= addr_nxt;
            wdata_q   <= wdata_nxt;
        end
    end

    assign bus.busy      = (state == COUNT) || (state == HI) || (state == LO) || (state == CSUM);
    assign bus.in_ready  = bus.busy;
    assign bus.done      = (state == DONE);
    assign bus.error     = (state == ERR);
    assign bus.cpu_hold  = (state != DONE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench: two loaders (base 0x00 and 0xFE) share one stimulus stream;
// writes are logged at the falling edge and checked against hand-computed values.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    logic [7:0]  wa_addr[$];
    logic [15:0] wa_data[$];
    int          wa_cyc[$];
    logic [7:0]  wb_addr[$];
    logic [15:0] wb_data[$];

    imem_loader_if #(.ADDR_W(8)) ia();
    imem_loader_if #(.ADDR_W(8)) ib();

    assign ia.start = start;  assign ia.in_valid = in_valid;  assign ia.in_data = in_data;
    assign ib.start = start;  assign ib.in_valid = in_valid;  assign ib.in_data = in_data;

    imem_loader #(.ADDR_W(8), .BASE_ADDR(0))    dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    imem_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ia.mem_we === 1'b1) begin
            wa_addr.push_back(ia.mem_addr); wa_data.push_back(ia.mem_wdata); wa_cyc.push_back(cyc);
        end
        if (ib.mem_we === 1'b1) begin
            wb_addr.push_back(ib.mem_addr); wb_data.push_back(ib.mem_wdata);
        end
    end

    task automatic clear_log();
        wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
        wb_addr.delete(); wb_data.delete();
    endtask

    // Present a byte until it is accepted; returns 1 ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        in_valid = 1'b1; in_data = b;
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = (ia.in_ready === 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_data = 8'hEE;
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_byte timeout: in_ready=%b required 1", ia.in_ready);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic check_two_writes(input string name);
        total++;
        if (wa_addr.size() !== 2 || wb_addr.size() !== 2) begin
            bad++; $display("FAIL %s write count: a=%0d b=%0d required 2", name, wa_addr.size(), wb_addr.size());
        end else begin
            total++;
            if ({wa_addr[0], wa_data[0], wa_addr[1], wa_data[1]} !== {8'h00, 16'h1234, 8'h01, 16'hABCD}) begin
                bad++; $display("FAIL %s writes a: %h@%h %h@%h required 1234@00 abcd@01", name,
                                wa_data[0], wa_addr[0], wa_data[1], wa_addr[1]);
            end
            total++;
            if ({wb_addr[0], wb_data[0], wb_addr[1], wb_data[1]} !== {8'hFE, 16'h1234, 8'hFF, 16'hABCD}) begin
                bad++; $display("FAIL %s writes b: %h@%h %h@%h required 1234@fe abcd@ff", name,
                                wb_data[0], wb_addr[0], wb_data[1], wb_addr[1]);
            end
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0; #1;
        total++;
        if ({ia.in_ready, ia.mem_we, ia.busy, ia.done, ia.error, ia.cpu_hold} !== 6'b000001) begin
            bad++; $display("FAIL reset flags: rdy/we/busy/done/err/hold=%b required 000001",
                            {ia.in_ready, ia.mem_we, ia.busy, ia.done, ia.error, ia.cpu_hold});
        end
        total++;
        if ({ia.mem_addr, ia.mem_wdata} !== 24'h0) begin
            bad++; $display("FAIL reset bus: addr=%h wdata=%h required 0", ia.mem_addr, ia.mem_wdata);
        end
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_good_frame();
        int c0;
        clear_log();
        pulse_start();
        total++;
        if ({ia.in_ready, ia.busy, ia.cpu_hold} !== 3'b111) begin
            bad++; $display("FAIL start_count rdy/busy/hold=%b required 111", {ia.in_ready, ia.busy, ia.cpu_hold});
        end
        send_byte(8'h02); c0 = cyc;
        send_byte(8'h12);
        send_byte(8'h34);
        total++;
        if ({ia.mem_we, ia.mem_addr, ia.mem_wdata} !== {1'b1, 8'h00, 16'h1234}) begin
            bad++; $display("FAIL write0 we=%b addr=%h data=%h required 1 00 1234", ia.mem_we, ia.mem_addr, ia.mem_wdata);
        end
        send_byte(8'hAB);
        total++;
        if ({ia.mem_we, ia.mem_addr, ia.mem_wdata} !== {1'b0, 8'h00, 16'h1234}) begin
            bad++; $display("FAIL strobe_width we=%b addr=%h data=%h required 0 00 1234", ia.mem_we, ia.mem_addr, ia.mem_wdata);
        end
        send_byte(8'hCD);
        send_byte(8'hC0);
        total++;
        if ({ia.done, ia.error, ia.cpu_hold, ia.busy, ia.in_ready} !== 5'b10000) begin
            bad++; $display("FAIL good_status done/err/hold/busy/rdy=%b required 10000",
                            {ia.done, ia.error, ia.cpu_hold, ia.busy, ia.in_ready});
        end
        // Six bytes on consecutive edges: checksum edge is 5 edges after the count edge.
        total++;
        if (cyc - c0 !== 5) begin
            bad++; $display("FAIL latency edges=%0d required 5", cyc - c0);
        end
        check_two_writes("good");
        if (wa_cyc.size() == 2) begin
            total++;
            if (wa_cyc[1] - wa_cyc[0] !== 2) begin
                bad++; $display("FAIL write_spacing=%0d required 2", wa_cyc[1] - wa_cyc[0]);
            end
        end
    endtask

    task automatic test_start_from_done();
        pulse_start();
        total++;
        if ({ia.done, ia.error, ia.cpu_hold, ia.busy} !== 4'b0011) begin
            bad++; $display("FAIL restart_done done/err/hold/busy=%b required 0011", {ia.done, ia.error, ia.cpu_hold, ia.busy});
        end
    endtask

    task automatic test_bad_csum();
        clear_log();
        send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hC1);
        total++;
        if ({ia.done, ia.error, ia.cpu_hold, ia.busy} !== 4'b0110) begin
            bad++; $display("FAIL bad_status done/err/hold/busy=%b required 0110", {ia.done, ia.error, ia.cpu_hold, ia.busy});
        end
        check_two_writes("bad");
    endtask

    task automatic test_midframe_start();
        clear_log();
        pulse_start();
        total++;
        if ({ia.error, ia.busy} !== 2'b01) begin
            bad++; $display("FAIL restart_err err/busy=%b required 01", {ia.error, ia.busy});
        end
        send_byte(8'h02); send_byte(8'h12);
        start = 1'b1;
        send_byte(8'h34); send_byte(8'hAB);
        start = 1'b0;
        send_byte(8'hCD); send_byte(8'hC0);
        total++;
        if ({ia.done, ia.error, ia.busy} !== 3'b100) begin
            bad++; $display("FAIL midstart done/err/busy=%b required 100", {ia.done, ia.error, ia.busy});
        end
        check_two_writes("midstart");
    endtask

    task automatic test_stall();
        logic [7:0] fr [6];
        fr = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        clear_log();
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            // Idle cycles carry a poison byte with in_valid low.
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0; in_data = 8'h5A; @(posedge clk); #1;
            end
            send_byte(fr[i]);
        end
        total++;
        if ({ia.done, ia.error} !== 2'b10) begin
            bad++; $display("FAIL stall done/err=%b required 10", {ia.done, ia.error});
        end
        check_two_writes("stall");
    endtask

    task automatic test_count0();
        int bad_a = 0, bad_b = 0;
        clear_log();
        pulse_start();
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h00); send_byte(8'(i));
        end
        send_byte(8'h80);  // 0x00 + sum(0..255) = 32640 = 0x7F80
        @(negedge clk); #1;
        total++;
        if ({ia.done, ib.done, ia.error} !== 3'b110) begin
            bad++; $display("FAIL count0 done_a/done_b/err=%b required 110", {ia.done, ib.done, ia.error});
        end
        total++;
        if (wa_addr.size() !== 256 || wb_addr.size() !== 256) begin
            bad++; $display("FAIL count0 strobes a=%0d b=%0d required 256", wa_addr.size(), wb_addr.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                if (wa_addr[i] !== 8'(i) || wa_data[i] !== 16'(i)) bad_a++;
                if (wb_addr[i] !== 8'(i + 254) || wb_data[i] !== 16'(i)) bad_b++;
            end
            total++;
            if (bad_a !== 0 || bad_b !== 0) begin
                bad++; $display("FAIL count0 word errors a=%0d b=%0d required 0", bad_a, bad_b);
            end
            total++;
            if ({wb_addr[0], wb_addr[1], wb_addr[2]} !== 24'hFEFF00) begin
                bad++; $display("FAIL count0 wrap addrs=%h %h %h required fe ff 00", wb_addr[0], wb_addr[1], wb_addr[2]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        clear_log();
        pulse_start();
        send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
        // Strobe for 0x1234 is in flight in this cycle; reset lands mid-cycle.
        #2 rst_n = 1'b0; #1;
        total++;
        if ({ia.in_ready, ia.mem_we, ia.busy, ia.done, ia.error, ia.cpu_hold} !== 6'b000001 ||
            {ia.mem_addr, ia.mem_wdata} !== 24'h0) begin
            bad++; $display("FAIL midreset rdy/we/busy/done/err/hold=%b addr=%h data=%h required 000001 00 0000",
                            {ia.in_ready, ia.mem_we, ia.busy, ia.done, ia.error, ia.cpu_hold}, ia.mem_addr, ia.mem_wdata);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        n = wa_addr.size();
        in_valid = 1'b1; in_data = 8'hAB;
        repeat (4) @(posedge clk);
        #1 in_valid = 1'b0;
        total++;
        if (wa_addr.size() !== n || ia.busy !== 1'b0) begin
            bad++; $display("FAIL post_reset writes=%0d busy=%b required %0d 0", wa_addr.size(), ia.busy, n);
        end
        clear_log();
        pulse_start();
        send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hC0);
        total++;
        if ({ia.done, ia.error, ia.cpu_hold} !== 3'b100) begin
            bad++; $display("FAIL reload done/err/hold=%b required 100", {ia.done, ia.error, ia.cpu_hold});
        end
        check_two_writes("reload");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_start_from_done();
        test_bad_csum();
        test_midframe_start();
        test_stall();
        test_count0();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
